// File: rtl/mem_access.sv
// Memory-access stage: one data-bus transaction per load/store, lane alignment and
// load extension, single-cycle ALU forwarding, and a one-cycle memory_valid pulse.
module mem_access #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              execute_valid,
    input  logic [31:0]       ex_ins,
    input  logic [63:0]       ex_pc,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_w,
    input  logic              ex_mem_r,
    input  logic              ex_mem_w,
    input  logic [2:0]        ex_msize,
    input  logic              ex_sig,
    input  logic [XLEN-1:0]   ex_data_out,
    input  logic [XLEN-1:0]   ex_rd2,
    input  logic              stall,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [XLEN-1:0]   dreq_data,
    input  logic              dresp_data_ok,
    input  logic [XLEN-1:0]   dresp_data,
    output logic              memory_valid,
    output logic [31:0]       mem_ins,
    output logic [63:0]       mem_pc,
    output logic [4:0]        mem_rd,
    output logic              mem_reg_w,
    output logic [XLEN-1:0]   mem_data_out,
    output logic              mem_misalign,
    output logic              memory_stall
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            r_state, w_next;
    logic [31:0]       r_ins;
    logic [63:0]       r_pc;
    logic [4:0]        r_rd;
    logic              r_reg_w, r_mem_r, r_mem_w, r_sig, r_misalign;
    logic [2:0]        r_msize;
    logic [XLEN-1:0]   r_data_out, r_rd2, r_result;

    logic              w_ex_mem, w_ex_misalign, w_store;
    logic [2:0]        w_off;
    logic [XLEN-1:0]   w_shifted, w_load;
    logic [7:0]        w_strobe;

    assign w_ex_mem  = ex_mem_r | ex_mem_w;
    assign w_off     = r_data_out[2:0];
    assign w_store   = r_mem_w & ~r_mem_r;
    assign w_shifted = dresp_data >> {w_off, 3'b000};

    always_comb begin
        w_ex_misalign = 1'b0;
        case (ex_msize[1:0])
            2'd0: w_ex_misalign = 1'b0;
            2'd1: w_ex_misalign = ex_data_out[0];
            2'd2: w_ex_misalign = |ex_data_out[1:0];
            2'd3: w_ex_misalign = |ex_data_out[2:0];
        endcase
    end

    always_comb begin
        w_load   = '0;
        w_strobe = '0;
        case (r_msize[1:0])
            2'd0: begin
                w_load   = {{(XLEN-8){r_sig & w_shifted[7]}}, w_shifted[7:0]};
                w_strobe = 8'h01 << w_off;
            end
            2'd1: begin
                w_load   = {{(XLEN-16){r_sig & w_shifted[15]}}, w_shifted[15:0]};
                w_strobe = 8'h03 << w_off;
            end
            2'd2: begin
                w_load   = {{(XLEN-32){r_sig & w_shifted[31]}}, w_shifted[31:0]};
                w_strobe = 8'h0F << w_off;
            end
            2'd3: begin
                w_load   = w_shifted;
                w_strobe = 8'hFF;
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (execute_valid) w_next = (w_ex_mem && !w_ex_misalign) ? REQ : DONE;
            REQ:  if (dresp_data_ok) w_next = DONE;
            DONE: if (!stall) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_ins      <= '0;
            r_pc       <= '0;
            r_rd       <= '0;
            r_reg_w    <= 1'b0;
            r_mem_r    <= 1'b0;
            r_mem_w    <= 1'b0;
            r_sig      <= 1'b0;
            r_misalign <= 1'b0;
            r_msize    <= '0;
            r_data_out <= '0;
            r_rd2      <= '0;
            r_result   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && execute_valid) begin
                r_ins      <= ex_ins;
                r_pc       <= ex_pc;
                r_rd       <= ex_rd;
                r_mem_r    <= ex_mem_r;
                r_mem_w    <= ex_mem_w;
                r_sig      <= ex_sig;
                r_msize    <= ex_msize;
                r_data_out <= ex_data_out;
                r_rd2      <= ex_rd2;
                // A misaligned access is dropped: no write-back and a zero result.
                r_misalign <= w_ex_mem & w_ex_misalign;
                r_reg_w    <= ex_reg_w & ~(w_ex_mem & w_ex_misalign);
                r_result   <= (w_ex_mem && w_ex_misalign) ? '0 : ex_data_out;
            end else if (r_state == REQ && dresp_data_ok && r_mem_r) begin
                r_result <= w_load;
            end
        end
    end

    assign memory_stall = (r_state != IDLE);
    assign dreq_valid   = (r_state == REQ);
    assign dreq_addr    = dreq_valid ? r_data_out[ADDR_W-1:0] : '0;
    assign dreq_size    = dreq_valid ? r_msize : '0;
    assign dreq_strobe  = (dreq_valid && w_store) ? w_strobe : '0;
    assign dreq_data    = (dreq_valid && w_store) ? (r_rd2 << {w_off, 3'b000}) : '0;
    assign memory_valid = (r_state == DONE) && !stall;
    assign mem_ins      = r_ins;
    assign mem_pc       = r_pc;
    assign mem_rd       = r_rd;
    assign mem_reg_w    = r_reg_w;
    assign mem_data_out = r_result;
    assign mem_misalign = r_misalign;

endmodule
